// File: rtl/instruction_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_loader_pkg
//  Purpose  : Shared state encoding and constants for the instruction loader.
//  Revision : 1.0  initial release
// ============================================================================
package instruction_loader_pkg;

   // Loader FSM states
   typedef enum logic [1:0] {
      RECV  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int          BYTES_PER_WORD    = 4;
   localparam int          BYTE_CNT_W        = 2;
   localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/instruction_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_loader_if
//  Purpose  : UART byte input and instruction-RAM write bus of the loader.
//  Revision : 1.0  initial release
// ============================================================================
interface instruction_loader_if #(
   parameter int len = 32
) ();
   logic           in_rx_done;
   logic [7:0]     in_rx_data;
   logic           out_wea;
   logic [len-1:0] out_addr;
   logic [len-1:0] out_data;
   logic           out_load_done;
   logic           out_overflow;
   logic [len-1:0] out_word_count;

   // Loader side: consumes bytes, drives the RAM write port and status
   modport master (
      input  in_rx_done, in_rx_data,
      output out_wea, out_addr, out_data, out_load_done, out_overflow, out_word_count
   );

   // Environment side: UART receiver and RAM / pipeline control
   modport slave (
      output in_rx_done, in_rx_data,
      input  out_wea, out_addr, out_data, out_load_done, out_overflow, out_word_count
   );
endinterface
`default_nettype wire

// File: rtl/instruction_loader_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_loader_word_assembler
//  Purpose  : Big-endian byte-to-word shift register. word/word_valid are
//             presented combinationally in the cycle the final byte arrives
//             so the caller can capture the complete word on that edge.
//  Revision : 1.0  initial release
// ============================================================================
module instruction_loader_word_assembler
   import instruction_loader_pkg::*;
#(
   parameter int len = 32
) (
   input  wire logic           clk,
   input  wire logic           reset,
   input  wire logic           clear,
   input  wire logic           byte_valid,
   input  wire logic [7:0]     byte_in,
   output logic     [len-1:0]  word,
   output logic                word_valid
);

   // Only the upper bytes need storage; the newest byte comes from the input
   logic [len-9:0]        hold;
   logic [BYTE_CNT_W-1:0] byte_cnt;

   assign word       = {hold, byte_in};
   assign word_valid = byte_valid && (byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

   // Shift each accepted byte in at the LSB end; restart the count per word
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         hold     <= '0;
         byte_cnt <= '0;
      end else if (byte_valid) begin
         hold     <= word[len-9:0];
         byte_cnt <= word_valid ? '0 : byte_cnt + BYTE_CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/instruction_loader.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_loader
//  Purpose  : Loads UART bytes as 32-bit words into instruction RAM from
//             address 0 until the halt word or RAM full, then flags done.
//  Revision : 1.0  initial release
// ============================================================================
module instruction_loader
   import instruction_loader_pkg::*;
#(
   parameter int             len       = 32,
   parameter int             RAM_DEPTH = 2048,
   parameter logic [len-1:0] HALT_WORD = len'(DEFAULT_HALT_WORD)
) (
   input  wire logic           clk,
   input  wire logic           reset,
   instruction_loader_if.master bus
);

   state_t         state;
   state_t         state_next;
   logic [len-1:0] addr;
   logic [len-1:0] word_count;
   logic [len-1:0] data;
   logic           overflow;

   logic [len-1:0] asm_word;
   logic           asm_valid;
   logic           byte_valid;
   logic           is_halt;
   logic           is_last_addr;

   // Bytes are ignored once loading has finished; partial bytes are dropped
   assign byte_valid   = bus.in_rx_done && (state != DONE);
   assign is_halt      = (data == HALT_WORD);
   assign is_last_addr = (addr == len'(RAM_DEPTH - 1));

   instruction_loader_word_assembler #(
      .len (len)
   ) u_word_assembler (
      .clk        (clk),
      .reset      (reset),
      .clear      (state == DONE),
      .byte_valid (byte_valid),
      .byte_in    (bus.in_rx_data),
      .word       (asm_word),
      .word_valid (asm_valid)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= RECV;
      else       state <= state_next;
   end

   // Next-state: one WRITE cycle per word, halt takes priority over RAM full
   always_comb begin
      state_next = state;
      case (state)
         RECV:    if (asm_valid) state_next = WRITE;
         WRITE:   state_next = (is_halt || is_last_addr) ? DONE : RECV;
         DONE:    state_next = DONE;
         default: state_next = RECV;
      endcase
   end

   // RAM-side registers: latch the word, then advance address/count after the write
   always_ff @(posedge clk) begin
      if (reset) begin
         data       <= '0;
         addr       <= '0;
         word_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (state == RECV && asm_valid) data <= asm_word;
         if (state == WRITE) begin
            addr       <= addr + len'(1);
            word_count <= word_count + len'(1);
            if (!is_halt && is_last_addr) overflow <= 1'b1;
         end
      end
   end

   // Outputs decoded from registered state only
   always_comb begin
      bus.out_wea        = (state == WRITE);
      bus.out_load_done  = (state == DONE);
      bus.out_addr       = addr;
      bus.out_data       = data;
      bus.out_overflow   = overflow;
      bus.out_word_count = word_count;
   end

endmodule
`default_nettype wire
